uart_transmitter: RTL

- Serialises one D_BIT-wide word per request into an asynchronous UART frame: start bit, LSB-first data, optional parity bit, stop period.
- Driven by the same 16x oversampling baud_sample_tick generator as the UART receiver.
- Sits between the host/FIFO side (tx_start, d_in) and the serial pin (tx).
- The tx line of this block loops directly into the receiver's rx for system loopback.

---
 rtl/uart_transmitter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/uart_transmitter.sv
// UART transmitter: start bit, LSB-first data, optional parity bit, stop period.
// Bit timing comes from a shared 16x oversampling baud_sample_tick.
module uart_transmitter #(
    parameter int D_BIT      = 8,
    parameter int SB_TICK    = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             baud_sample_tick,
    input  logic             tx_start,
    input  logic [D_BIT-1:0] d_in,
    output logic             tx,
    output logic             tx_busy,
    output logic             tx_done
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic [4:0] BIT_LAST  = 5'd15;
    localparam logic [4:0] STOP_LAST = 5'(SB_TICK - 1);
    localparam logic [2:0] N_LAST    = 3'(D_BIT - 1);
    localparam logic       ODD_SENSE = (PARITY_ODD != 0);

    state_t           state;
    logic [4:0]       s_count;
    logic [2:0]       n;
    logic [D_BIT-1:0] shreg;
    logic             par_bit;

    // tx is loaded with the value of the state being entered, so the pin
    // changes on the same edge as the state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            s_count <= '0;
            n       <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
            tx      <= 1'b1;
            tx_done <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (tx_start) begin
                        shreg   <= d_in;
                        par_bit <= (^d_in) ^ ODD_SENSE;
                        s_count <= '0;
                        state   <= START;
                        tx      <= 1'b0;
                    end
                end
                START: begin
                    tx <= 1'b0;
                    if (baud_sample_tick) begin
                        if (s_count == BIT_LAST) begin
                            s_count <= '0;
                            n       <= '0;
                            state   <= DATA;
                            tx      <= shreg[0];
                        end else begin
                            s_count <= s_count + 5'd1;
                        end
                    end
                end
                DATA: begin
                    tx <= shreg[0];
                    if (baud_sample_tick) begin
                        if (s_count == BIT_LAST) begin
                            s_count <= '0;
                            shreg   <= shreg >> 1;
                            if (n == N_LAST) begin
                                if (PARITY_EN != 0) begin
                                    state <= PARITY;
                                    tx    <= par_bit;
                                end else begin
                                    state <= STOP;
                                    tx    <= 1'b1;
                                end
                            end else begin
                                n  <= n + 3'd1;
                                tx <= shreg[1];
                            end
                        end else begin
                            s_count <= s_count + 5'd1;
                        end
                    end
                end
                PARITY: begin
                    tx <= par_bit;
                    if (baud_sample_tick) begin
                        if (s_count == BIT_LAST) begin
                            s_count <= '0;
                            state   <= STOP;
                            tx      <= 1'b1;
                        end else begin
                            s_count <= s_count + 5'd1;
                        end
                    end
                end
                STOP: begin
                    tx <= 1'b1;
                    if (baud_sample_tick) begin
                        if (s_count == STOP_LAST) begin
                            s_count <= '0;
                            state   <= IDLE;
                            tx_done <= 1'b1;
                        end else begin
                            s_count <= s_count + 5'd1;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    s_count <= '0;
                    tx      <= 1'b1;
                end
            endcase
        end
    end

    assign tx_busy = (state != IDLE);

endmodule
